// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: bus widths, frame sync byte and
// the loader state encoding.
package boot_loader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  // The loader takes stream bytes in every state except the two terminal ones.
  function automatic logic accepts_bytes(input state_e s);
    return (s != S_DONE) && (s != S_ERROR);
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte stream in, instruction memory write port out. The master side feeds
// bytes and observes writes; the slave side is the loader itself.
interface boot_loader_if;
  import boot_loader_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/boot_loader.sv
// Program loader: parses HEADER / count / word bytes / checksum frames,
// writes 16-bit words into instruction memory and holds the core in reset
// until a checksum-verified image is in place.
module boot_loader
  import boot_loader_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  boot_loader_if.slave bus,
  input  logic         restart,
  output logic         core_rst,
  output logic         done,
  output logic         err
);

  state_e            state_q, state_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        word_idx_q, word_idx_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        xor_q, xor_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic take;
  logic last_word;

  // Ready is a pure decode of state, forced low while reset is applied.
  assign bus.in_ready = ~rst & accepts_bytes(state_q);
  assign take         = bus.in_valid & bus.in_ready;
  assign last_word    = (word_idx_q == count_q - 8'd1);

  // Next-state, datapath and write-strobe decode for one byte per cycle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    hi_d       = hi_q;
    xor_d      = xor_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        // Anything other than the sync byte is swallowed.
        if (take && bus.in_data == HEADER) begin
          state_d = S_COUNT;
          xor_d   = 8'h00;
        end
      end
      S_COUNT: begin
        if (take) begin
          count_d    = bus.in_data;
          word_idx_d = 8'd0;
          state_d    = (bus.in_data == 8'd0) ? S_CHECK : S_HI;
        end
      end
      S_HI: begin
        if (take) begin
          hi_d    = bus.in_data;
          xor_d   = xor_q ^ bus.in_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (take) begin
          xor_d      = xor_q ^ bus.in_data;
          we_d       = 1'b1;
          addr_d     = word_idx_q;
          wdata_d    = {hi_q, bus.in_data};
          word_idx_d = word_idx_q + 8'd1;
          state_d    = last_word ? S_CHECK : S_HI;
        end
      end
      S_CHECK: begin
        if (take) begin
          state_d = (bus.in_data == xor_q) ? S_DONE : S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        // Only the terminal states honour restart; memory contents stay.
        if (restart) begin
          state_d = S_IDLE;
          xor_d   = 8'h00;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= 8'd0;
      word_idx_q <= 8'd0;
      hi_q       <= 8'd0;
      xor_q      <= 8'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      hi_q       <= hi_d;
      xor_q      <= xor_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERROR);
  assign core_rst = (state_q != S_DONE);

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected memory writes are queued as
// words are sent; a negedge monitor pops and compares each imem_we pulse.
module tb_boot_loader;
  import boot_loader_pkg::*;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic restart = 1'b0;
  logic core_rst, done, err;

  boot_loader_if bus();

  boot_loader dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .restart  (restart),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  wr_t         sb[$];
  logic [15:0] frame_q[$];
  logic        prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.imem_we) begin
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h at %0t",
                 bus.imem_addr, bus.imem_wdata, $time);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", {24'd0, bus.imem_addr}, {24'd0, e.addr});
        check("wr_data", {16'd0, bus.imem_wdata}, {16'd0, e.data});
      end
    end
    prev_we = bus.imem_we;
  end

  // Offer one byte, optionally after an in_valid gap, and wait for acceptance.
  task automatic send_byte(input logic [7:0] b, input int stall);
    logic rdy;
    int   waited;
    if (stall > 0) begin
      bus.in_valid = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    waited = 0;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      waited++;
    end while (!rdy && waited < 50);
    #1;
    bus.in_valid = 1'b0;
    if (!rdy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: byte %0h not accepted after %0d cycles", b, waited);
    end
  endtask

  // Send HEADER, count, the words in frame_q and the given checksum byte.
  task automatic send_frame(input logic [7:0] csum, input int stall_max);
    send_byte(HEADER, 0);
    send_byte(8'(frame_q.size()), 0);
    for (int i = 0; i < frame_q.size(); i++) begin
      sb.push_back('{addr: 8'(i), data: frame_q[i]});
      send_byte(frame_q[i][15:8], (stall_max > 0) ? int'($urandom_range(1, stall_max)) : 0);
      send_byte(frame_q[i][7:0],  (stall_max > 0) ? int'($urandom_range(1, stall_max)) : 0);
    end
    send_byte(csum, 0);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},       {31'd0, bus.imem_we}, 32'd0);
    check({tag, "_addr"},     {24'd0, bus.imem_addr}, 32'd0);
    check({tag, "_wdata"},    {16'd0, bus.imem_wdata}, 32'd0);
    check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
    check({tag, "_done"},     {31'd0, done}, 32'd0);
    check({tag, "_err"},      {31'd0, err}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset: ready low while rst is high, reset values after the edge.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    #1;
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Frame A; a restart pulse during HI must be ignored.
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    sb.push_back('{addr: 8'h00, data: 16'h1234});
    sb.push_back('{addr: 8'h01, data: 16'h5678});
    send_byte(8'h12, 0);
    restart = 1'b1;
    send_byte(8'h34, 0);
    restart = 1'b0;
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    send_byte(8'h08, 0);
    check("a_done",     {31'd0, done}, 32'd1);
    check("a_core_rst", {31'd0, core_rst}, 32'd0);
    check("a_err",      {31'd0, err}, 32'd0);
    check("a_in_ready", {31'd0, bus.in_ready}, 32'd0);

    // Restart with in_valid high in DONE: restart wins, byte not taken.
    bus.in_valid = 1'b1;
    bus.in_data  = HEADER;
    pulse_restart();
    bus.in_valid = 1'b0;
    check("rs_done",     {31'd0, done}, 32'd0);
    check("rs_core_rst", {31'd0, core_rst}, 32'd1);
    check("rs_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Same frame, bad checksum: writes still happen, then ERROR.
    frame_q = '{16'h1234, 16'h5678};
    send_frame(8'h09, 0);
    check("b_err",      {31'd0, err}, 32'd1);
    check("b_done",     {31'd0, done}, 32'd0);
    check("b_core_rst", {31'd0, core_rst}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("b_core_rst_held", {31'd0, core_rst}, 32'd1);
    pulse_restart();
    check("b_err_clr",  {31'd0, err}, 32'd0);
    check("b_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Garbage ahead of an empty frame: no writes, checksum 00 accepted.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h3C, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("g_done", {31'd0, done}, 32'd1);
    check("g_err",  {31'd0, err}, 32'd0);
    pulse_restart();

    // Stalled frame: DE^AD^BE^EF^01^02 = 21.
    frame_q = '{16'hDEAD, 16'hBEEF, 16'h0102};
    send_frame(8'h21, 5);
    check("s_done",     {31'd0, done}, 32'd1);
    check("s_core_rst", {31'd0, core_rst}, 32'd0);
    pulse_restart();

    // rst after the first word of a 3-word frame.
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    sb.push_back('{addr: 8'h00, data: 16'h1122});
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    frame_q = '{16'hABCD};
    send_frame(8'h66, 0);
    check("r_done", {31'd0, done}, 32'd1);
    pulse_restart();

    // Full 255-word frame: word i = {i, ~i}, so each word XORs to FF and
    // 255 of them fold to FF.
    frame_q.delete();
    for (int i = 0; i < 255; i++) frame_q.push_back({8'(i), ~8'(i)});
    send_frame(8'hFF, 0);
    check("n_done",      {31'd0, done}, 32'd1);
    check("n_last_addr", {24'd0, bus.imem_addr}, 32'd254);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("n_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("n_done_held", {31'd0, done}, 32'd1);

    repeat (4) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
